// File: rtl/ddr3_wr_arbiter.sv
// ============================================================================
//  Module   : ddr3_wr_arbiter
//  Purpose  : Round-robin arbiter sharing one DDR3 write port between NUM_CH
//             acquisition streams. Each stream has its own address region and
//             a done flag. Define DDR3_ARB_STATS_EN to add per-channel beat
//             counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_wr_arbiter #(
    parameter int NUM_CH    = 5,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 23,
    parameter int BURST_LEN = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        fill_start,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_last,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [NUM_CH-1:0]        ddr3_wr_done,
    output logic [CH_W-1:0]          grant_ch,
    output logic                     arb_busy
`ifdef DDR3_ARB_STATS_EN
    ,
    input  logic                     stats_clear,
    input  logic [CH_W-1:0]          stats_sel,
    output logic [31:0]              stats_beats
`endif
);

    localparam int LOW_W  = ADDR_W - CH_W;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_GRANT = 3'b010;
    localparam logic [2:0] S_XFER  = 3'b100;

    logic [2:0]        r_state;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   r_last_grant;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [LOW_W-1:0]  r_addr_low [NUM_CH];
    logic [NUM_CH-1:0] r_done;

    logic [DATA_W-1:0] w_ch_data [NUM_CH];
    logic              w_found;
    logic [CH_W-1:0]   w_next_ch;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic              w_accept;
    logic              w_burst_end;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_data
        assign w_ch_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Two passes give the rotating priority: channels above last_grant first,
    // then wrap around to channel 0 up to and including last_grant.
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && req_valid[j] && (CH_W'(j) > r_last_grant)) begin
                w_found   = 1'b1;
                w_next_ch = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && req_valid[j] && (CH_W'(j) <= r_last_grant)) begin
                w_found   = 1'b1;
                w_next_ch = CH_W'(j);
            end
        end
    end

    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_last  = req_last[r_grant];
    assign wr_valid    = (r_state == S_XFER) && w_sel_valid;
    assign w_accept    = wr_valid && wr_ready;
    assign w_burst_end = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));

    assign wr_data      = w_ch_data[r_grant];
    assign wr_addr      = {r_grant, r_addr_low[r_grant]};
    assign grant_ch     = r_grant;
    assign arb_busy     = (r_state != S_IDLE);
    assign ddr3_wr_done = r_done;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = w_accept && (r_grant == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_next_ch;
                        r_beat_cnt <= '0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_state <= S_XFER;
                end
                S_XFER: begin
                    // An empty channel gives the port up rather than stalling others.
                    if (!w_sel_valid) begin
                        r_state      <= S_IDLE;
                        r_last_grant <= r_grant;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        if (w_burst_end || w_sel_last) begin
                            r_state      <= S_IDLE;
                            r_last_grant <= r_grant;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Only the region offset counts; it wraps inside the region.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_addr_low[i] <= '0;
            end
            r_done <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fill_start[i]) begin
                    r_addr_low[i] <= '0;
                    r_done[i]     <= 1'b0;
                end else if (w_accept && (r_grant == CH_W'(i))) begin
                    r_addr_low[i] <= r_addr_low[i] + LOW_W'(1);
                    if (req_last[i]) begin
                        r_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef DDR3_ARB_STATS_EN
    logic [31:0] r_stats_cnt [NUM_CH];
    logic [31:0] w_stats_val;

    always_comb begin
        w_stats_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (stats_sel == CH_W'(k)) begin
                w_stats_val = r_stats_cnt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_stats_cnt[i] <= '0;
            end
            stats_beats <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stats_clear) begin
                    r_stats_cnt[i] <= '0;
                end else if (w_accept && (r_grant == CH_W'(i)) && (r_stats_cnt[i] != '1)) begin
                    r_stats_cnt[i] <= r_stats_cnt[i] + 32'd1;
                end
            end
            stats_beats <= w_stats_val;
        end
    end
`endif

endmodule

`default_nettype wire
